// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: state encoding and sizing helper shared by the AES vector sequencer.
package aes_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_GAP, S_FINISH} seq_state_e;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/aes_vec_mem.sv
// aes_vec_mem: NUM_VEC-entry {plaintext, key, expected ciphertext} register file.
// Synchronous write; two combinational read ports (launch side and check side).
module aes_vec_mem import aes_seq_pkg::*; #(
  parameter int DATA_W  = 128,
  parameter int NUM_VEC = 4,
  localparam int ADDR_W = addr_w(NUM_VEC)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_pt,
  input  logic [DATA_W-1:0] i_key,
  input  logic [DATA_W-1:0] i_ct,
  input  logic [ADDR_W-1:0] i_drv_addr,
  input  logic [ADDR_W-1:0] i_chk_addr,
  output logic [DATA_W-1:0] o_pt,
  output logic [DATA_W-1:0] o_key,
  output logic [DATA_W-1:0] o_ct
);
  typedef struct packed {
    logic [DATA_W-1:0] pt;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] ct;
  } vec_t;
  vec_t r_mem [NUM_VEC];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= '{pt: i_pt, key: i_key, ct: i_ct};
  assign o_pt  = r_mem[i_drv_addr].pt;
  assign o_key = r_mem[i_drv_addr].key;
  assign o_ct  = r_mem[i_chk_addr].ct;
endmodule

// File: rtl/aes_vector_sequencer.sv
// aes_vector_sequencer: drives stored vectors into an AES core, captures its
// result on the valid strobe, compares against the expected ciphertext and counts.
module aes_vector_sequencer import aes_seq_pkg::*; #(
  parameter int DATA_W  = 128,
  parameter int NUM_VEC = 4,
  parameter int EN_HOLD = 51,
  parameter int GAP     = 15,
  parameter int TIMEOUT = 300,
  parameter int CNT_W   = 16,
  localparam int ADDR_W = addr_w(NUM_VEC)
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              vec_we,
  input  logic [ADDR_W-1:0] vec_addr,
  input  logic [DATA_W-1:0] vec_pt,
  input  logic [DATA_W-1:0] vec_key,
  input  logic [DATA_W-1:0] vec_ct,
  input  logic              start,
  input  logic              loop_en,
  input  logic              abort,
  output logic              drv_en,
  output logic [DATA_W-1:0] drv_data,
  output logic [DATA_W-1:0] drv_key,
  input  logic [DATA_W-1:0] dut_data_out,
  input  logic              dut_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] last_fail_idx
);
  localparam int CNT_MAX = (EN_HOLD > GAP) ? EN_HOLD : GAP;
  localparam int HC_W = $clog2(CNT_MAX + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [HC_W-1:0] HOLD_END = HC_W'(EN_HOLD - 1);
  localparam logic [HC_W-1:0] GAP_END = HC_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_VEC - 1);
  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [HC_W-1:0]   r_cnt;
  logic [TO_W-1:0]   r_to;
  logic              r_cap;
  logic [DATA_W-1:0] r_cap_data;
  logic              r_drv_en;
  logic [DATA_W-1:0] r_drv_data;
  logic [DATA_W-1:0] r_drv_key;
  logic              r_done;
  logic [CNT_W-1:0]  r_pass;
  logic [CNT_W-1:0]  r_fail;
  logic              r_timeout_err;
  logic [ADDR_W-1:0] r_last_fail;
  logic [ADDR_W-1:0] w_nxt_idx;
  logic [ADDR_W-1:0] w_drv_addr;
  logic [DATA_W-1:0] w_pt;
  logic [DATA_W-1:0] w_key;
  logic [DATA_W-1:0] w_ct;
  logic              w_we;
  logic              w_cap_now;
  logic              w_pass;
  logic              w_finish;
  logic              w_launch;
  assign w_nxt_idx  = (r_idx == LAST) ? '0 : r_idx + ADDR_W'(1);
  assign w_drv_addr = (r_state == S_IDLE) ? '0 : w_nxt_idx;
  assign w_we       = vec_we && r_state == S_IDLE;
  // Only the first valid per vector is kept; later strobes are ignored.
  assign w_cap_now  = dut_valid && !r_cap && (r_state == S_DRIVE || r_state == S_WAIT);
  assign w_pass     = r_cap && r_cap_data == w_ct;
  assign w_finish   = r_idx == LAST && !loop_en;
  assign w_launch   = (r_state == S_IDLE)  ? start :
                      (r_state == S_GAP)   ? r_cnt == GAP_END :
                      (r_state == S_CHECK) && GAP == 0 && !w_finish;
  aes_vec_mem #(.DATA_W(DATA_W), .NUM_VEC(NUM_VEC)) u_mem (
    .i_clk      (AES_clk),
    .i_we       (w_we),
    .i_waddr    (vec_addr),
    .i_pt       (vec_pt),
    .i_key      (vec_key),
    .i_ct       (vec_ct),
    .i_drv_addr (w_drv_addr),
    .i_chk_addr (r_idx),
    .o_pt       (w_pt),
    .o_key      (w_key),
    .o_ct       (w_ct)
  );
  always_ff @(posedge AES_clk or negedge AES_rst_n)
    if (!AES_rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_to          <= '0;
      r_cap         <= 1'b0;
      r_cap_data    <= '0;
      r_drv_en      <= 1'b0;
      r_drv_data    <= '0;
      r_drv_key     <= '0;
      r_done        <= 1'b0;
      r_pass        <= '0;
      r_fail        <= '0;
      r_timeout_err <= 1'b0;
      r_last_fail   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_cap_now) begin
        r_cap      <= 1'b1;
        r_cap_data <= dut_data_out;
      end
      if (r_state == S_DRIVE || r_state == S_WAIT) r_to <= r_to + TO_W'(1);
      if (r_state == S_CHECK) begin
        if (w_pass) r_pass <= (r_pass == '1) ? r_pass : r_pass + CNT_W'(1);
        else begin
          r_fail      <= (r_fail == '1) ? r_fail : r_fail + CNT_W'(1);
          r_last_fail <= r_idx;
          if (!r_cap) r_timeout_err <= 1'b1;
        end
      end
      if (abort) begin
        r_state  <= S_IDLE;
        r_drv_en <= 1'b0;
      end else if (w_launch) begin
        r_state    <= S_DRIVE;
        r_idx      <= w_drv_addr;
        r_cnt      <= '0;
        r_to       <= '0;
        r_cap      <= 1'b0;
        r_drv_en   <= 1'b1;
        r_drv_data <= w_pt;
        r_drv_key  <= w_key;
        if (r_state == S_IDLE) begin
          r_pass        <= '0;
          r_fail        <= '0;
          r_timeout_err <= 1'b0;
          r_last_fail   <= '0;
        end
      end else begin
        case (r_state)
          S_DRIVE:
            if (r_cnt == HOLD_END) begin
              r_drv_en <= 1'b0;
              r_state  <= (r_cap || dut_valid) ? S_CHECK : S_WAIT;
            end else r_cnt <= r_cnt + HC_W'(1);
          S_WAIT: if (dut_valid || r_to == TO_END) r_state <= S_CHECK;
          S_CHECK:
            if (w_finish) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_GAP;
              r_cnt   <= '0;
            end
          S_GAP:   r_cnt <= r_cnt + HC_W'(1);
          default: r_state <= S_IDLE;
        endcase
      end
    end
  assign drv_en        = r_drv_en;
  assign drv_data      = r_drv_data;
  assign drv_key       = r_drv_key;
  assign busy          = r_state != S_IDLE;
  assign done          = r_done;
  assign pass_cnt      = r_pass;
  assign fail_cnt      = r_fail;
  assign timeout_err   = r_timeout_err;
  assign last_fail_idx = r_last_fail;
endmodule
